// File: rtl/risc_pkg.sv
// risc_pkg: shared core types, including the unified-memory arbiter state and owner encodings.
package risc_pkg;
  typedef enum logic [1:0] {DMEM_BYTE, DMEM_HALF, DMEM_WORD} op_dmem_size;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_e;
  typedef enum logic {ARB_OWN_I, ARB_OWN_D} arb_owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the unified-memory arbiter.
interface mem_arbiter_if import risc_pkg::*; ();
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_zero_ex, d_gnt, d_rvalid;
  op_dmem_size d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_wr, m_zero_ex;
  op_dmem_size m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_size, d_zero_ex, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_req, m_wr, m_size, m_zero_ex, m_addr, m_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_wr, d_size, d_zero_ex, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_req, m_wr, m_size, m_zero_ex, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// arb_pick: data-over-fetch priority, yielding to fetch once the data streak is exhausted.
module arb_pick #(
  parameter int MAX_D_STREAK = 4,
  parameter int SW = 3
) (
  input  logic          i_req_i,
  input  logic          d_req_i,
  input  logic [SW-1:0] streak_i,
  output logic          grant_i_o,
  output logic          grant_d_o
);
  always_comb begin
    grant_d_o = d_req_i && !(i_req_i && streak_i == SW'(MAX_D_STREAK));
    grant_i_o = i_req_i && !grant_d_o;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between fetch and data, one transaction at a time.
module mem_arbiter import risc_pkg::*; #(
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input logic         clk,
  input logic         res,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  arb_state_e  state_q;
  arb_owner_e  owner_q;
  logic [SW-1:0] streak_q;
  logic [LW-1:0] lat_q;
  logic        wr_q, zex_q;
  op_dmem_size size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic pick_i, pick_d, gnt_i, gnt_d, acc, resp;
  arb_pick #(.MAX_D_STREAK(MAX_D_STREAK), .SW(SW)) u_pick (
    .i_req_i  (bus.i_req),
    .d_req_i  (bus.d_req),
    .streak_i (streak_q),
    .grant_i_o(pick_i),
    .grant_d_o(pick_d)
  );
  // grants are combinational but masked during reset so every output reads 0
  always_comb begin
    gnt_i = !res && state_q == ARB_IDLE && pick_i;
    gnt_d = !res && state_q == ARB_IDLE && pick_d;
    acc   = state_q == ARB_ACCESS;
    resp  = state_q == ARB_RESP;
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= ARB_IDLE;
      owner_q  <= ARB_OWN_I;
      streak_q <= '0;
      lat_q    <= '0;
      wr_q     <= 1'b0;
      zex_q    <= 1'b0;
      size_q   <= DMEM_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: if (gnt_i || gnt_d) begin
          state_q  <= ARB_ACCESS;
          lat_q    <= LW'(MEM_LATENCY - 1);
          owner_q  <= gnt_d ? ARB_OWN_D : ARB_OWN_I;
          wr_q     <= gnt_d && bus.d_wr;
          zex_q    <= gnt_d && bus.d_zero_ex;
          size_q   <= gnt_d ? bus.d_size : DMEM_WORD;
          addr_q   <= gnt_d ? bus.d_addr : bus.i_addr;
          wdata_q  <= gnt_d ? bus.d_wdata : '0;
          streak_q <= (gnt_d && bus.i_req) ? streak_q + SW'(streak_q != SW'(MAX_D_STREAK)) : '0;
        end
        ARB_ACCESS: begin
          lat_q <= lat_q - LW'(lat_q != '0);
          if (lat_q == '0) begin
            rdata_q <= wr_q ? '0 : bus.m_rdata;
            state_q <= ARB_RESP;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
  always_comb begin
    bus.i_gnt     = gnt_i;
    bus.d_gnt     = gnt_d;
    bus.i_rvalid  = resp && owner_q == ARB_OWN_I;
    bus.d_rvalid  = resp && owner_q == ARB_OWN_D;
    bus.i_rdata   = bus.i_rvalid ? rdata_q : '0;
    bus.d_rdata   = bus.d_rvalid ? rdata_q : '0;
    bus.m_req     = acc;
    bus.m_wr      = acc && wr_q;
    bus.m_zero_ex = acc && zex_q;
    bus.m_size    = acc ? size_q : DMEM_BYTE;
    bus.m_addr    = acc ? addr_q : '0;
    bus.m_wdata   = acc ? wdata_q : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, streak limit, stores, reset and withdrawal.
module tb_mem_arbiter;
  import risc_pkg::*;
  logic clk = 1'b0;
  logic res = 1'b1;
  logic [31:0] mem_val = '0;
  int n_chk = 0;
  int n_fail = 0;
  mem_arbiter_if bus();
  assign bus.m_rdata = bus.m_req ? mem_val : 32'h0;
  mem_arbiter #(.MEM_LATENCY(2), .MAX_D_STREAK(4)) dut (.clk(clk), .res(res), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] pat;
    int ng, both, rv;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_size = DMEM_BYTE; bus.d_zero_ex = 1'b0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    mid;
    chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_size", 32'(bus.m_size), 32'(DMEM_BYTE));
    chk("rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
    nxt;
    res = 1'b0; bus.i_req = 1'b0;
    nxt;
    // fetch alone
    bus.i_req = 1'b1; bus.i_addr = 32'h100; mem_val = 32'h13;
    mid; chk("f_i_gnt", 32'(bus.i_gnt), 32'd1); chk("f_d_gnt", 32'(bus.d_gnt), 32'd0);
    nxt; bus.i_req = 1'b0;
    mid; chk("f_m_req1", 32'(bus.m_req), 32'd1); chk("f_m_addr", bus.m_addr, 32'h100);
    chk("f_m_wr", 32'(bus.m_wr), 32'd0); chk("f_m_size", 32'(bus.m_size), 32'(DMEM_WORD));
    nxt;
    mid; chk("f_m_req2", 32'(bus.m_req), 32'd1); chk("f_early_rv", 32'(bus.i_rvalid), 32'd0);
    nxt;
    mid; chk("f_i_rvalid", 32'(bus.i_rvalid), 32'd1); chk("f_i_rdata", bus.i_rdata, 32'h13);
    chk("f_m_req3", 32'(bus.m_req), 32'd0); chk("f_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    nxt;
    // simultaneous requests: data first
    bus.i_req = 1'b1; bus.i_addr = 32'h104; mem_val = 32'h55AA;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h2000; bus.d_size = DMEM_HALF; bus.d_zero_ex = 1'b1;
    mid; chk("s_d_gnt", 32'(bus.d_gnt), 32'd1); chk("s_i_gnt0", 32'(bus.i_gnt), 32'd0);
    nxt; bus.d_req = 1'b0;
    mid; chk("s_m_addr", bus.m_addr, 32'h2000); chk("s_m_size", 32'(bus.m_size), 32'(DMEM_HALF));
    chk("s_m_zex", 32'(bus.m_zero_ex), 32'd1);
    nxt; nxt;
    mid; chk("s_d_rvalid", 32'(bus.d_rvalid), 32'd1); chk("s_d_rdata", bus.d_rdata, 32'h55AA);
    chk("s_i_rv3", 32'(bus.i_rvalid), 32'd0); chk("s_i_gnt3", 32'(bus.i_gnt), 32'd0);
    nxt;
    mid; chk("s_i_gnt4", 32'(bus.i_gnt), 32'd1);
    nxt; bus.i_req = 1'b0;
    nxt; nxt;
    mid; chk("s_i_rvalid7", 32'(bus.i_rvalid), 32'd1); chk("s_i_rdata", bus.i_rdata, 32'h55AA);
    nxt;
    // streak limit with both requests held
    bus.d_zero_ex = 1'b0; bus.d_size = DMEM_WORD;
    bus.i_req = 1'b1; bus.d_req = 1'b1; pat = '0; ng = 0; both = 0;
    for (int c = 0; c < 24; c++) begin
      mid;
      if (bus.i_gnt && bus.d_gnt) both++;
      if (bus.i_gnt || bus.d_gnt) begin ng++; pat = {pat[4:0], bus.d_gnt}; end
      nxt;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("st_count", 32'(ng), 32'd6);
    chk("st_pattern", 32'(pat), 32'b111101);
    chk("st_both", 32'(both), 32'd0);
    nxt;
    // store
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEADBEEF; mem_val = 32'h12345678;
    mid; chk("w_d_gnt", 32'(bus.d_gnt), 32'd1);
    nxt; bus.d_req = 1'b0;
    mid; chk("w_m_wr1", 32'(bus.m_wr), 32'd1); chk("w_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    chk("w_m_addr", bus.m_addr, 32'h10);
    nxt;
    mid; chk("w_m_wr2", 32'(bus.m_wr), 32'd1);
    nxt;
    mid; chk("w_d_rvalid", 32'(bus.d_rvalid), 32'd1); chk("w_d_rdata", bus.d_rdata, 32'h0);
    nxt; bus.d_wr = 1'b0;
    // asynchronous reset during ACCESS
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    mid; chk("r_i_gnt", 32'(bus.i_gnt), 32'd1);
    nxt; bus.i_req = 1'b0;
    mid; chk("r_m_req", 32'(bus.m_req), 32'd1);
    #1 res = 1'b1;
    #1 chk("r_async_m_req", 32'(bus.m_req), 32'd0); chk("r_async_m_addr", bus.m_addr, 32'h0);
    nxt; res = 1'b0; rv = 0;
    for (int c = 0; c < 4; c++) begin
      mid;
      if (bus.i_rvalid || bus.d_rvalid || bus.m_req) rv++;
      nxt;
    end
    chk("r_no_rvalid", 32'(rv), 32'd0);
    bus.d_req = 1'b1; bus.d_addr = 32'h300; mem_val = 32'hA5;
    mid; chk("r_d_gnt", 32'(bus.d_gnt), 32'd1);
    nxt; bus.d_req = 1'b0; nxt; nxt;
    mid; chk("r_d_rdata", bus.d_rdata, 32'hA5); chk("r_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    nxt;
    // data request withdrawn while fetch is in ACCESS
    bus.i_req = 1'b1; bus.i_addr = 32'h400; mem_val = 32'h77;
    mid; chk("x_i_gnt", 32'(bus.i_gnt), 32'd1);
    nxt; bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h800;
    mid; chk("x_d_gnt", 32'(bus.d_gnt), 32'd0); chk("x_m_addr", bus.m_addr, 32'h400);
    chk("x_m_wr", 32'(bus.m_wr), 32'd0);
    nxt; bus.d_req = 1'b0;
    mid; chk("x_m_addr2", bus.m_addr, 32'h400);
    nxt;
    mid; chk("x_i_rvalid", 32'(bus.i_rvalid), 32'd1); chk("x_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("x_i_rdata", bus.i_rdata, 32'h77);
    nxt; rv = 0;
    for (int c = 0; c < 4; c++) begin
      mid;
      if (bus.d_gnt || bus.m_req || bus.d_rvalid) rv++;
      nxt;
    end
    chk("x_idle_quiet", 32'(rv), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
